// File: rtl/count_display_pkg.sv
// Shared constants for the count display: seven-segment font, blank pattern
// and the width of the digit-slot index.
package count_display_pkg;

    localparam int IDX_W = 2;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low patterns, seg[0]=a .. seg[6]=g, glyphs 0..9 then A b C d E F.
    localparam logic [6:0] FONT_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/count_display_seg7_decoder.sv
// Nibble to active-low seven-segment pattern, with a blank override.
// Purely combinational; the caller registers the result.
module seg7_decoder
    import count_display_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = FONT_TABLE[nibble];
        if (blank) seg = SEG_BLANK;
    end

endmodule

// File: rtl/count_display.sv
// Four-digit multiplexed display of a 0..15 count: decimal on the right two
// digits, hex on the left; one-cycle registered outputs, no backpressure.
module count_display
    import count_display_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int FLASH_FRAMES = 64,
    parameter int BLANK_LZ     = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] value,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_start
);

    localparam int PS_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int FL_W = $clog2(FLASH_FRAMES + 1);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(REFRESH_DIV - 1);
    localparam logic [FL_W-1:0] FL_LOAD = FL_W'(FLASH_FRAMES);

    logic [PS_W-1:0]  prescaler;
    logic [IDX_W-1:0] idx;
    logic [3:0]       snap;
    logic [FL_W-1:0]  flash;
    logic             tick;
    logic             wrap;

    assign tick = (prescaler == PS_LAST);
    assign wrap = tick && (idx == '1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler <= '0;
            idx       <= '0;
        end else begin
            prescaler <= tick ? '0 : prescaler + 1'b1;
            if (tick) idx <= idx + 1'b1;
        end
    end

    // snap only moves at frame boundaries so a frame never mixes two counts;
    // a fresh change outranks the per-frame decrement.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap        <= '0;
            flash       <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= wrap;
            if (wrap) begin
                snap <= value;
                if (value != snap)    flash <= FL_LOAD;
                else if (flash != '0) flash <= flash - 1'b1;
            end
        end
    end

    logic       tens;
    logic [3:0] ones;
    logic [3:0] dig_nib;
    logic       dig_blank;
    logic [6:0] dig_seg;

    assign tens = (snap >= 4'd10);
    assign ones = tens ? snap - 4'd10 : snap;

    always_comb begin
        dig_nib   = 4'd0;
        dig_blank = 1'b1;
        case (idx)
            2'd0: begin dig_nib = ones; dig_blank = 1'b0; end
            2'd1: begin dig_nib = {3'd0, tens}; dig_blank = !tens && (BLANK_LZ != 0); end
            2'd2: begin dig_nib = 4'd0; dig_blank = 1'b1; end
            default: begin dig_nib = snap; dig_blank = 1'b0; end
        endcase
    end

    seg7_decoder u_dec (
        .nibble (dig_nib),
        .blank  (dig_blank),
        .seg    (dig_seg)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= 4'hF;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= ~(4'b0001 << idx);
            seg <= dig_seg;
            dp  <= !((idx == '0) && (flash != '0));
        end
    end

endmodule

// File: tb/tb_count_display.sv
// Scoreboard bench for count_display with a 4-cycle digit slot and a
// 2-frame change indicator; expected digit outputs come from a bench model.
module tb_count_display;

    localparam int RD = 4;
    localparam int FF = 2;

    logic       clk = 1'b0;
    logic       clk_en = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] value = 4'd0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_start;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } disp_t;

    disp_t exp_q[$];
    logic [3:0] m_snap;
    int         m_flash;

    count_display #(.REFRESH_DIV(RD), .FLASH_FRAMES(FF), .BLANK_LZ(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .value       (value),
        .an          (an),
        .seg         (seg),
        .dp          (dp),
        .frame_start (frame_start)
    );

    initial forever begin
        #5;
        if (clk_en) clk = ~clk;
    end

    task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] font(input int d);
        case (d)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  9: return 7'h10;  10: return 7'h08; 11: return 7'h03;
            12: return 7'h46; 13: return 7'h21; 14: return 7'h06; default: return 7'h0E;
        endcase
    endfunction

    function automatic disp_t model_digit(input int slot, input int v, input int fl);
        disp_t d;
        d.an = 4'hF;
        d.an[slot] = 1'b0;
        d.dp = 1'b1;
        case (slot)
            0: begin d.seg = font(v % 10); d.dp = (fl == 0); end
            1: d.seg = (v >= 10) ? font(v / 10) : 7'h7F;
            2: d.seg = 7'h7F;
            default: d.seg = font(v);
        endcase
        return d;
    endfunction

    task automatic pop_check(input string tag);
        disp_t e;
        disp_t g;
        g = '{an: an, seg: seg, dp: dp};
        if (exp_q.size() == 0) begin
            check({tag, "_empty"}, 12'd1, 12'd0);
        end else begin
            e = exp_q.pop_front();
            check(tag, 12'(g), 12'(e));
        end
    endtask

    // After rst release: count cycles to the first frame_start, checking the
    // idle snap=0 display along the way.
    task automatic reset_to_first_frame(input string tag);
        int n = 0;
        while (!frame_start && n < 8 * RD) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (n == 2) check({tag, "_pre_digit0"}, 12'({4'hE, 7'h40, 1'b1}), 12'({an, seg, dp}));
        end
        check({tag, "_first_fs_cycles"}, 12'(n), 12'(4 * RD));
    endtask

    task automatic run_frame(input string tag, input bit mid_chg, input logic [3:0] mid_val);
        int n = 0;
        while (!frame_start && n < 8 * RD) begin
            @(negedge clk);
            n++;
        end
        if (!frame_start) begin
            check({tag, "_fs_timeout"}, 12'd0, 12'd1);
        end else begin
            if (value != m_snap) m_flash = FF;
            else if (m_flash > 0) m_flash--;
            m_snap = value;
            for (int k = 0; k < 4; k++) exp_q.push_back(model_digit(k, int'(m_snap), m_flash));
            @(negedge clk);
            check({tag, "_fs_width"}, 12'(frame_start), 12'd0);
            pop_check({tag, "_d0"});
            for (int k = 1; k < 4; k++) begin
                repeat (RD) @(negedge clk);
                pop_check($sformatf("%s_d%0d", tag, k));
                if (k == 1 && mid_chg) value = mid_val;
            end
        end
    endtask

    initial begin
        // Reset with no clock running: outputs must clear asynchronously.
        value = 4'd7;
        #3 rst = 1'b1;
        #1;
        check("async_rst_stopped", 12'({an, seg, dp}), 12'({4'hF, 7'h7F, 1'b1}));
        check("async_rst_fs", 12'(frame_start), 12'd0);
        clk_en = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        m_snap = 4'd0;
        m_flash = 0;
        reset_to_first_frame("boot");

        run_frame("v7_f1", 1'b0, 4'd0);
        run_frame("v7_f2", 1'b0, 4'd0);
        run_frame("v7_f3", 1'b0, 4'd0);
        value = 4'd12;
        run_frame("v12_f1", 1'b0, 4'd0);
        run_frame("v12_f2", 1'b0, 4'd0);
        value = 4'd15;
        run_frame("v15", 1'b0, 4'd0);
        value = 4'd0;
        run_frame("wrap0_f1", 1'b0, 4'd0);
        run_frame("wrap0_f2_midchg", 1'b1, 4'd5);
        run_frame("reload_over_dec", 1'b0, 4'd0);
        run_frame("v5_f2", 1'b0, 4'd0);
        run_frame("v5_f3", 1'b0, 4'd0);
        value = 4'd10;
        run_frame("v10", 1'b0, 4'd0);

        // Mid-frame, mid-flash reset: nothing may survive.
        repeat (RD + 1) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midscan_rst", 12'({an, seg, dp}), 12'({4'hF, 7'h7F, 1'b1}));
        check("midscan_rst_fs", 12'(frame_start), 12'd0);
        exp_q.delete();
        @(negedge clk);
        value = 4'd9;
        rst = 1'b0;
        m_snap = 4'd0;
        m_flash = 0;
        reset_to_first_frame("rerun");
        run_frame("v9_after_rst", 1'b0, 4'd0);
        run_frame("v9_f2", 1'b0, 4'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
